// File: rtl/cv32e40p_tb_exit_periph.sv
// Testbench-side data-bus slave: stdout FIFO, pass/fail status flags and a drain-aware exit request.
// Optional watchdog enabled by defining TB_PERIPH_WATCHDOG_EN (uses MAX_CYCLES).
module cv32e40p_tb_exit_periph #(
  parameter logic [31:0] PRINT_ADDR  = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
  parameter logic [31:0] CYCLE_ADDR  = 32'h1500_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MAX_CYCLES  = 32'd10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] PASS_CODE     = 32'd123456789;
  localparam logic [31:0] FAIL_CODE     = 32'd1;
  localparam logic [31:0] WATCHDOG_CODE = 32'hDEAD_0001;

  typedef enum logic [1:0] {
    EXIT_IDLE,
    EXIT_PENDING,
    EXIT_DONE
  } exit_state_e;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      cycle_q;
  exit_state_e      exit_state_q;

  logic is_print;
  logic is_status;
  logic is_exit;
  logic is_cycle;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic print_blocked;
  logic wr_gnt;
  logic rd_gnt;
  logic watchdog_fire;
  logic [31:0] rd_value;
  logic unused_bus;

  assign is_print  = (data_addr_i[31:2] == PRINT_ADDR[31:2]);
  assign is_status = (data_addr_i[31:2] == STATUS_ADDR[31:2]);
  assign is_exit   = (data_addr_i[31:2] == EXIT_ADDR[31:2]);
  assign is_cycle  = (data_addr_i[31:2] == CYCLE_ADDR[31:2]);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && char_ready_i;

  // A print into a full FIFO is only stalled if no slot frees up this same cycle.
  assign print_blocked = data_we_i && is_print && fifo_full && !pop;
  assign data_gnt_o    = data_req_i && !print_blocked;
  assign wr_gnt        = data_gnt_o && data_we_i;
  assign rd_gnt        = data_gnt_o && !data_we_i;
  assign push          = wr_gnt && is_print && data_be_i[0];

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  assign unused_bus = ^{data_be_i[3:1], data_addr_i[1:0]};

`ifdef TB_PERIPH_WATCHDOG_EN
  assign watchdog_fire = (cycle_q == MAX_CYCLES) && !tests_passed_o && !tests_failed_o
                         && !exit_valid_o;
`else
  logic unused_max_cycles;
  assign watchdog_fire     = 1'b0;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= data_wdata_i[7:0];
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    if (rd_gnt) begin
      if (is_cycle) begin
        rd_value = cycle_q;
      end else if (is_print) begin
        rd_value = 32'(count_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      cycle_q       <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= rd_value;
      cycle_q       <= cycle_q + 32'd1;
    end
  end

  // Exit waits for stdout to drain; the watchdog path skips the drain entirely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_state_q   <= EXIT_IDLE;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else begin
      if (wr_gnt && is_status) begin
        if (data_wdata_i == PASS_CODE) begin
          tests_passed_o <= 1'b1;
        end
        if (data_wdata_i == FAIL_CODE) begin
          tests_failed_o <= 1'b1;
        end
      end
      case (exit_state_q)
        EXIT_IDLE: begin
          if (wr_gnt && is_exit) begin
            exit_state_q <= EXIT_PENDING;
            exit_value_o <= data_wdata_i;
          end
        end
        EXIT_PENDING: begin
          if (fifo_empty && !push) begin
            exit_state_q <= EXIT_DONE;
            exit_valid_o <= 1'b1;
          end
        end
        EXIT_DONE: begin
          exit_state_q <= EXIT_DONE;
        end
        default: begin
          exit_state_q <= EXIT_IDLE;
        end
      endcase
      if (watchdog_fire) begin
        tests_failed_o <= 1'b1;
        exit_valid_o   <= 1'b1;
        exit_value_o   <= WATCHDOG_CODE;
        exit_state_q   <= EXIT_DONE;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tb_exit_periph.sv
// Directed self-checking bench for cv32e40p_tb_exit_periph: prints, backpressure, status, exit, cycle counter, reset.
module tb_cv32e40p_tb_exit_periph;

  localparam logic [31:0] PRINT_ADDR  = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h1500_1000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        char_ready_i = 1'b0;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  int checkCount = 0;
  int failCount  = 0;

  cv32e40p_tb_exit_periph #(
    .FIFO_DEPTH (8),
    .MAX_CYCLES (32'd100)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .char_valid_o   (char_valid_o),
    .char_data_o    (char_data_o),
    .char_ready_i   (char_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the grant edge with the response sampled.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic rvalid,
                               output logic [31:0] rdata);
    int waitCycles;
    waitCycles   = 0;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    data_be_i    = be;
    #1;
    while (!data_gnt_o && waitCycles < 50) begin
      @(negedge clk_i);
      #1;
      waitCycles++;
    end
    if (!data_gnt_o) checkOutput("gnt_timeout", 32'(data_gnt_o), 32'd1);
    @(negedge clk_i);
    rvalid       = data_rvalid_o;
    rdata        = data_rdata_o;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    data_be_i    = '0;
  endtask

  logic        rv;
  logic [31:0] rd;
  logic [31:0] firstCycle;
  logic [31:0] expChars [8];

  initial begin
    repeat (3) @(negedge clk_i);
    checkOutput("reset_gnt", 32'(data_gnt_o), 32'd0);
    checkOutput("reset_rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("reset_char_valid", 32'(char_valid_o), 32'd0);
    checkOutput("reset_char_data", 32'(char_data_o), 32'd0);
    checkOutput("reset_flags", 32'({tests_passed_o, tests_failed_o, exit_valid_o}), 32'd0);
    checkOutput("reset_exit_value", exit_value_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // "Hi" with the consumer stalled, then released
    applyStimulus(1'b1, PRINT_ADDR, 32'("H"), 4'b0001, rv, rd);
    checkOutput("print_rvalid", 32'(rv), 32'd1);
    checkOutput("print_rdata", rd, 32'd0);
    checkOutput("hi_valid_after_grant", 32'(char_valid_o), 32'd1);
    checkOutput("hi_head_H", 32'(char_data_o), 32'("H"));
    applyStimulus(1'b1, PRINT_ADDR, 32'("i"), 4'b0001, rv, rd);
    checkOutput("hi_head_held", 32'(char_data_o), 32'("H"));
    @(negedge clk_i);
    char_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("hi_second_char", 32'(char_data_o), 32'("i"));
    checkOutput("hi_second_valid", 32'(char_valid_o), 32'd1);
    @(negedge clk_i);
    checkOutput("hi_empty", 32'(char_valid_o), 32'd0);
    char_ready_i = 1'b0;

    // Fill to depth, ninth print must stall until a pop frees a slot
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, PRINT_ADDR, 32'h61 + 32'(i), 4'b0001, rv, rd);
    end
    applyStimulus(1'b0, PRINT_ADDR, 32'd0, 4'hF, rv, rd);
    checkOutput("fill_count_full", rd, 32'd8);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_addr_i  = PRINT_ADDR;
    data_wdata_i = 32'("9");
    data_be_i    = 4'b0001;
    #1;
    checkOutput("full_gnt_blocked", 32'(data_gnt_o), 32'd0);
    @(negedge clk_i);
    #1;
    checkOutput("full_gnt_still_blocked", 32'(data_gnt_o), 32'd0);
    char_ready_i = 1'b1;
    #1;
    checkOutput("full_gnt_on_pop", 32'(data_gnt_o), 32'd1);
    @(negedge clk_i);
    char_ready_i = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    checkOutput("full_push_rvalid", 32'(data_rvalid_o), 32'd1);
    applyStimulus(1'b0, PRINT_ADDR, 32'd0, 4'hF, rv, rd);
    checkOutput("fill_count_after_swap", rd, 32'd8);
    for (int k = 0; k < 7; k++) expChars[k] = 32'h62 + 32'(k);
    expChars[7] = 32'("9");
    char_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("drain_order", 32'(char_data_o), expChars[k]);
      @(negedge clk_i);
    end
    checkOutput("drain_empty", 32'(char_valid_o), 32'd0);
    char_ready_i = 1'b0;

    // Status flags are sticky and independent
    applyStimulus(1'b1, STATUS_ADDR, 32'd123456789, 4'hF, rv, rd);
    checkOutput("status_rvalid", 32'(rv), 32'd1);
    checkOutput("status_passed", 32'(tests_passed_o), 32'd1);
    checkOutput("status_not_failed", 32'(tests_failed_o), 32'd0);
    repeat (3) @(negedge clk_i);
    checkOutput("status_passed_held", 32'(tests_passed_o), 32'd1);
    checkOutput("status_rvalid_pulse", 32'(data_rvalid_o), 32'd0);
    applyStimulus(1'b1, STATUS_ADDR, 32'd1, 4'hF, rv, rd);
    checkOutput("status_failed", 32'(tests_failed_o), 32'd1);
    checkOutput("status_passed_kept", 32'(tests_passed_o), 32'd1);

    // Exit waits for the queued characters to drain
    applyStimulus(1'b1, PRINT_ADDR, 32'("x"), 4'b0001, rv, rd);
    applyStimulus(1'b1, PRINT_ADDR, 32'("y"), 4'b0001, rv, rd);
    applyStimulus(1'b1, PRINT_ADDR, 32'("z"), 4'b0001, rv, rd);
    applyStimulus(1'b1, EXIT_ADDR, 32'd5, 4'hF, rv, rd);
    repeat (3) @(negedge clk_i);
    checkOutput("exit_held_for_drain", 32'(exit_valid_o), 32'd0);
    char_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("exit_drained_empty", 32'(char_valid_o), 32'd0);
    checkOutput("exit_not_yet", 32'(exit_valid_o), 32'd0);
    @(negedge clk_i);
    checkOutput("exit_valid", 32'(exit_valid_o), 32'd1);
    checkOutput("exit_value", exit_value_o, 32'd5);
    char_ready_i = 1'b0;
    applyStimulus(1'b1, EXIT_ADDR, 32'd7, 4'hF, rv, rd);
    checkOutput("exit_first_wins", exit_value_o, 32'd5);
    checkOutput("exit_sticky", 32'(exit_valid_o), 32'd1);

    // Cycle counter reads granted 10 cycles apart
    applyStimulus(1'b0, CYCLE_ADDR, 32'd0, 4'hF, rv, rd);
    firstCycle = rd;
    repeat (9) @(negedge clk_i);
    applyStimulus(1'b0, CYCLE_ADDR, 32'd0, 4'hF, rv, rd);
    checkOutput("cycle_delta", rd - firstCycle, 32'd10);

    // Unmapped read and a print without byte 0 enabled
    applyStimulus(1'b0, 32'h3000_0000, 32'd0, 4'hF, rv, rd);
    checkOutput("unmapped_rvalid", 32'(rv), 32'd1);
    checkOutput("unmapped_rdata", rd, 32'd0);
    applyStimulus(1'b1, PRINT_ADDR, 32'("Q"), 4'b0010, rv, rd);
    checkOutput("print_no_be0", 32'(char_valid_o), 32'd0);

    // Reset mid-drain with a response in flight
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, PRINT_ADDR, 32'h30 + 32'(i), 4'b0001, rv, rd);
    end
    char_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("midreset_char_valid", 32'(char_valid_o), 32'd0);
    checkOutput("midreset_char_data", 32'(char_data_o), 32'd0);
    checkOutput("midreset_flags", 32'({tests_passed_o, tests_failed_o, exit_valid_o}), 32'd0);
    checkOutput("midreset_exit_value", exit_value_o, 32'd0);
    char_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    applyStimulus(1'b0, PRINT_ADDR, 32'd0, 4'hF, rv, rd);
    checkOutput("postreset_count", rd, 32'd0);

`ifdef TB_PERIPH_WATCHDOG_EN
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (90) @(negedge clk_i);
    checkOutput("watchdog_quiet", 32'(tests_failed_o), 32'd0);
    repeat (20) @(negedge clk_i);
    checkOutput("watchdog_failed", 32'(tests_failed_o), 32'd1);
    checkOutput("watchdog_exit", 32'(exit_valid_o), 32'd1);
    checkOutput("watchdog_value", exit_value_o, 32'hDEAD_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
